// File: rtl/bp_fe_pkg.sv
// Shared front-end predictor types: the BHT sequencing states and the
// {idx, ghist} metadata struct that travels from predict to resolve.
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`define BP_FE_DECLARE_BHT_META_S(idx_w, ghist_w) \
  typedef struct packed { \
    logic [idx_w-1:0]   idx; \
    logic [ghist_w-1:0] ghist; \
  } bp_fe_bht_meta_s;

package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_clear = 2'd1,
    e_run   = 2'd2
  } bp_fe_bht_state_e;

endpackage

`endif

// File: rtl/bp_fe_sat_ctr.sv
// Saturating up/down counter step: returns cnt_i moved one toward
// all-ones (up_i=1) or zero (up_i=0), holding at either end.
module bp_fe_sat_ctr #(
  parameter int width_p = 2
) (
  input  logic [width_p-1:0] cnt_i,
  input  logic               up_i,
  output logic [width_p-1:0] cnt_o
);

  localparam logic [width_p-1:0] max_lp = '1;

  always_comb begin
    cnt_o = cnt_i;
    if (up_i) begin
      if (cnt_i != max_lp) cnt_o = cnt_i + 1'b1;
    end else begin
      if (cnt_i != '0) cnt_o = cnt_i - 1'b1;
    end
  end

endmodule

// File: rtl/bp_fe_bht_gshare.sv
// Gshare direction predictor: PC xor speculative global history indexes a
// table of saturating counters, cleared by a hardware sweep after reset.
//
// state   | meaning
// e_reset | one idle cycle after reset release
// e_clear | sweep writes weakly-not-taken into one entry per cycle
// e_run   | predictions and updates accepted
module bp_fe_bht_gshare
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p   = 39,
  parameter int bht_idx_width_p = 9,
  parameter int ghist_width_p   = 8,
  parameter int ctr_width_p     = 2,
  parameter int debug_p         = 0,
  localparam int meta_width_lp  = bht_idx_width_p + ghist_width_p
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  output logic                     init_done_o,
  input  logic                     r_v_i,
  input  logic [vaddr_width_p-1:0] pc_i,
  output logic                     predict_v_o,
  output logic                     predict_o,
  output logic [meta_width_lp-1:0] meta_o,
  input  logic                     w_v_i,
  input  logic [meta_width_lp-1:0] meta_i,
  input  logic                     taken_i,
  input  logic                     correct_i
);

  `BP_FE_DECLARE_BHT_META_S(bht_idx_width_p, ghist_width_p)

  localparam int els_lp = 2 ** bht_idx_width_p;
  localparam logic [ctr_width_p-1:0] weak_nt_lp = {1'b0, {(ctr_width_p-1){1'b1}}};

  bp_fe_bht_state_e state_r, state_n;
  logic clear_en, run_en;
  logic [bht_idx_width_p-1:0] init_cnt_r;

  logic [ctr_width_p-1:0] mem_r [els_lp];
  logic [ctr_width_p-1:0] upd_ctr;

  logic [ghist_width_p-1:0]   ghr_r, ghr_n, ghr_spec, ghr_fix;
  logic [bht_idx_width_p-1:0] ghr_ext, r_idx;
  logic                       r_accept, w_accept;
  bp_fe_bht_meta_s            w_meta;

  logic                     predict_v_r, predict_r;
  logic [meta_width_lp-1:0] meta_r;
  logic                     unused_bits;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_reset;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_reset: state_n = e_clear;
      e_clear: if (init_cnt_r == '1) state_n = e_run;
      e_run:   state_n = e_run;
      default: state_n = e_reset;
    endcase
  end

  always_comb begin
    clear_en    = (state_r == e_clear);
    run_en      = (state_r == e_run);
    init_done_o = run_en;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)       init_cnt_r <= '0;
    else if (clear_en) init_cnt_r <= init_cnt_r + 1'b1;
  end

  assign w_meta   = meta_i;
  assign r_accept = r_v_i & run_en;
  assign w_accept = w_v_i & run_en;
  assign ghr_ext  = bht_idx_width_p'(ghr_r);
  assign r_idx    = pc_i[bht_idx_width_p+1:2] ^ ghr_ext;

  bp_fe_sat_ctr #(
    .width_p(ctr_width_p)
  ) sat_ctr (
    .cnt_i(mem_r[w_meta.idx]),
    .up_i (taken_i),
    .cnt_o(upd_ctr)
  );

  // Reads sample the array before this edge's write lands, so a same-index
  // read and update in one cycle returns the old counter.
  always_ff @(posedge clk_i) begin
    if (clear_en && !reset_i) mem_r[init_cnt_r] <= weak_nt_lp;
    else if (w_accept && !reset_i) mem_r[w_meta.idx] <= upd_ctr;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      predict_v_r <= 1'b0;
      predict_r   <= 1'b0;
      meta_r      <= '0;
    end else begin
      predict_v_r <= r_accept;
      if (r_accept) begin
        predict_r <= mem_r[r_idx][ctr_width_p-1];
        meta_r    <= {r_idx, ghr_r};
      end
    end
  end

  assign predict_v_o = predict_v_r;
  assign predict_o   = predict_r;
  assign meta_o      = meta_r;

  if (ghist_width_p == 1) begin : g_ghr1
    assign ghr_spec = predict_r;
    assign ghr_fix  = taken_i;
  end else begin : g_ghrn
    assign ghr_spec = {ghr_r[ghist_width_p-2:0], predict_r};
    assign ghr_fix  = {w_meta.ghist[ghist_width_p-2:0], taken_i};
  end

  // A mispredict repair wins over the shift of a prediction that is
  // already stale and about to be flushed.
  always_comb begin
    ghr_n = ghr_r;
    if (w_accept && !correct_i) ghr_n = ghr_fix;
    else if (predict_v_r)       ghr_n = ghr_spec;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ghr_r <= '0;
    else         ghr_r <= ghr_n;
  end

  assign unused_bits = ^{pc_i[vaddr_width_p-1:bht_idx_width_p+2], pc_i[1:0],
                         w_meta.ghist[ghist_width_p-1]};

  if (debug_p != 0) begin : g_debug
    always @(negedge clk_i) begin
      if (predict_v_o)
        $write("bht rd  meta=%h pred=%b\n", meta_o, predict_o);
      if (w_accept)
        $write("bht upd idx=%h taken=%b correct=%b ctr=%h->%h\n",
               w_meta.idx, taken_i, correct_i, mem_r[w_meta.idx], upd_ctr);
    end
  end

endmodule

// File: tb/tb_bp_fe_bht_gshare.sv
// Scoreboard bench for the gshare predictor: 16-entry table, 4-bit history,
// 3-bit counters (weakly-not-taken = 3, saturate at 7).
module tb_bp_fe_bht_gshare;

  localparam int vaddr_lp = 32;
  localparam int idx_lp   = 4;
  localparam int gh_lp    = 4;
  localparam int ctr_lp   = 3;
  localparam int meta_lp  = idx_lp + gh_lp;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic                init_done_o;
  logic                r_v_i;
  logic [vaddr_lp-1:0] pc_i;
  logic                predict_v_o;
  logic                predict_o;
  logic [meta_lp-1:0]  meta_o;
  logic                w_v_i;
  logic [meta_lp-1:0]  meta_i;
  logic                taken_i;
  logic                correct_i;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  int         n_init;

  always #5 clk_i = ~clk_i;

  bp_fe_bht_gshare #(
    .vaddr_width_p  (vaddr_lp),
    .bht_idx_width_p(idx_lp),
    .ghist_width_p  (gh_lp),
    .ctr_width_p    (ctr_lp),
    .debug_p        (0)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .init_done_o(init_done_o),
    .r_v_i      (r_v_i),
    .pc_i       (pc_i),
    .predict_v_o(predict_v_o),
    .predict_o  (predict_o),
    .meta_o     (meta_o),
    .w_v_i      (w_v_i),
    .meta_i     (meta_i),
    .taken_i    (taken_i),
    .correct_i  (correct_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented prediction is matched against the oldest expectation.
  always @(negedge clk_i) begin
    if (predict_v_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_predict_v", predict_v_o, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("predict_o", predict_o, mon_e[8]);
        check("meta_idx", meta_o[7:4], mon_e[7:4]);
        check("meta_ghist", meta_o[3:0], mon_e[3:0]);
      end
    end
  end

  task automatic cyc(input logic rv, input logic [3:0] pc4, input logic wv,
                     input logic [3:0] widx, input logic [3:0] wgh,
                     input logic tk, input logic cr, input logic [8:0] ex);
    r_v_i     = rv;
    pc_i      = 32'h1234_56C3 | {26'd0, pc4, 2'b00};
    w_v_i     = wv;
    meta_i    = {widx, wgh};
    taken_i   = tk;
    correct_i = cr;
    if (rv) exp_q.push_back(ex);
    @(posedge clk_i); #1;
    r_v_i = 1'b0; w_v_i = 1'b0; meta_i = '0; taken_i = 1'b0; correct_i = 1'b1;
  endtask

  task automatic rd(input logic [3:0] pc4, input logic ep, input logic [3:0] ei, input logic [3:0] eg);
    cyc(1'b1, pc4, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, {ep, ei, eg});
  endtask

  task automatic up(input logic [3:0] i, input logic [3:0] g, input logic t, input logic c);
    cyc(1'b0, 4'd0, 1'b1, i, g, t, c, 9'd0);
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 9'd0);
  endtask

  // Counts edges after reset release until init_done_o; 0 if it never rises.
  task automatic wait_init(input int pulse_at, output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      r_v_i = (k == pulse_at);
      pc_i  = 32'h1234_56C3;
      @(posedge clk_i); #1;
      r_v_i = 1'b0;
      if (init_done_o) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    reset_i = 1'b1; r_v_i = 1'b0; pc_i = '0; w_v_i = 1'b0;
    meta_i = '0; taken_i = 1'b0; correct_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_init_done", init_done_o, 0);
    check("rst_predict_v", predict_v_o, 0);
    check("rst_predict", predict_o, 0);
    check("rst_meta", meta_o, 0);

    // Init sweep; a request during the sweep must produce nothing
    reset_i = 1'b0;
    wait_init(5, n_init);
    check("init_latency", n_init, 17);

    for (int k = 0; k < 16; k++) rd(k[3:0], 1'b0, k[3:0], 4'd0);
    idle();

    // Saturation at idx 5 (GHR moves as predictions are made)
    up(5, 0, 1, 1);
    rd(5, 1, 5, 0);
    up(5, 0, 1, 1); up(5, 0, 1, 1); up(5, 0, 1, 1); up(5, 0, 1, 1);
    up(5, 0, 0, 1); up(5, 0, 0, 1); up(5, 0, 0, 1);
    rd(4, 1, 5, 1);
    up(5, 0, 0, 1);
    rd(6, 0, 5, 3);
    up(5, 0, 0, 1); up(5, 0, 0, 1); up(5, 0, 0, 1); up(5, 0, 0, 1);
    up(5, 0, 1, 1); up(5, 0, 1, 1); up(5, 0, 1, 1);
    rd(3, 0, 5, 6);
    up(5, 0, 1, 1);
    rd(9, 1, 5, 12);
    idle();

    // GHR shift T,N,T from a repaired GHR of 0000
    up(15, 0, 0, 0);
    rd(5, 1, 5, 0);
    rd(0, 0, 0, 0);
    rd(4, 1, 5, 1);
    idle();
    rd(3, 0, 6, 5);
    idle();

    // Recovery overrides the same-cycle speculative shift
    rd(10, 0, 0, 10);
    up(7, 10, 1, 0);
    rd(2, 1, 7, 5);
    idle();

    // Same-index read/update, then back-to-back updates to one entry
    cyc(1'b1, 4'd8, 1'b1, 4'd3, 4'd0, 1'b1, 1'b1, {1'b0, 4'd3, 4'd11});
    rd(8, 1, 3, 11);
    up(9, 0, 0, 1); up(9, 0, 0, 1); up(9, 0, 1, 1); up(9, 0, 1, 1);
    rd(4, 0, 9, 13);
    up(9, 0, 1, 1);
    rd(3, 1, 9, 10);
    idle();

    // Reset during operation clears outputs
    reset_i = 1'b1;
    idle();
    check("midrst_predict_v", predict_v_o, 0);
    check("midrst_predict", predict_o, 0);
    check("midrst_meta", meta_o, 0);
    check("midrst_init_done", init_done_o, 0);

    // Reset again while the sweep is on entry 7
    reset_i = 1'b0;
    repeat (8) idle();
    reset_i = 1'b1;
    idle();
    check("sweep_rst_init_done", init_done_o, 0);
    reset_i = 1'b0;
    wait_init(0, n_init);
    check("resweep_latency", n_init, 17);

    rd(5, 0, 5, 0);
    rd(7, 0, 7, 0);
    rd(9, 0, 9, 0);
    rd(3, 0, 3, 0);
    idle();
    idle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
